symm_route: RTL and testbench

SYMM_ROUTE -- requirements
Module: symm_route

---
 rtl/symm_pkg.sv | 33 +++
 rtl/symm_bank.sv | 50 +++++
 rtl/symm_route.sv | 172 +++++++++++++++++
 tb/tb_symm_route.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/symm_pkg.sv
// Shared definitions for the symmetric-matrix router: element width default,
// matrix dimension, FSM state type, load lengths and the upper-triangle
// visiting order used when SYMM_ROUTE_SYMFILL_EN is defined.
package symm_pkg;

  localparam int SYMM_DW_DEF = 26;
  localparam int SYMM_N      = 4;
  localparam int NUM_FULL    = SYMM_N * SYMM_N;
  localparam int NUM_SYM     = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } symm_state_e;

  // Flat row-major position {row,col} of the k-th upper-triangle transfer.
  localparam logic [3:0] TRI_IDX [NUM_SYM] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15
  };

  // Guarded table lookup; out-of-range transfer numbers map to element 0.
  function automatic logic [3:0] tri_lookup(input logic [3:0] k);
    logic [3:0] pos;
    if (k < 4'(NUM_SYM)) begin
      pos = TRI_IDX[k];
    end else begin
      pos = 4'd0;
    end
    return pos;
  endfunction

endpackage

// File: rtl/symm_bank.sv
// One 4x4 register bank. A write stores wdata bit-exact at flat position
// idx = {row,col}; with mirror set the transposed position {col,row} is
// written in the same cycle.
module symm_bank
  import symm_pkg::*;
#(
  parameter int DW = SYMM_DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     mirror,
  input  logic [3:0]               idx,
  input  logic [DW-1:0]            wdata,
  output logic [NUM_FULL*DW-1:0]   mat
);

  logic [NUM_FULL*DW-1:0] mat_d;
  logic [NUM_FULL*DW-1:0] mat_q;
  logic [3:0]             midx_s;

  assign midx_s = {idx[1:0], idx[3:2]};

  // Next bank contents: hold unless a write strobe arrives.
  always_comb begin
    mat_d = mat_q;
    if (we) begin
      mat_d[idx*DW +: DW] = wdata;
      if (mirror) begin
        mat_d[midx_s*DW +: DW] = wdata;
      end else begin
        mat_d[midx_s*DW +: DW] = mat_d[midx_s*DW +: DW];
      end
    end else begin
      mat_d = mat_q;
    end
  end

  // Bank storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q <= '0;
    end else begin
      mat_q <= mat_d;
    end
  end

  assign mat = mat_q;

endmodule

// File: rtl/symm_route.sv
// Routes a stream of signed elements into one of two 4x4 banks.
// FSM: IDLE -> LOAD -> DONE -> IDLE. Abort returns from LOAD to IDLE.
// Optional build macro SYMM_ROUTE_SYMFILL_EN: load only the upper triangle
// (10 transfers) and mirror each off-diagonal element.
module symm_route
  import symm_pkg::*;
#(
  parameter int DW = SYMM_DW_DEF,
  parameter int N  = SYMM_N
) (
  input  logic                 clk_rt,
  input  logic                 rstn_rt,
  input  logic                 en_rt,
  input  logic                 dest,
  input  logic                 abort_rt,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic [N*N*DW-1:0]    oa_mat,
  output logic [N*N*DW-1:0]    ob_mat,
  output logic                 a_valid,
  output logic                 b_valid,
  output logic                 busy,
  output logic                 done
);

`ifdef SYMM_ROUTE_SYMFILL_EN
  localparam logic [3:0] LAST_IDX = 4'(NUM_SYM - 1);
`else
  localparam logic [3:0] LAST_IDX = 4'(NUM_FULL - 1);
`endif

  symm_state_e state_d, state_q;
  logic [3:0]  idx_d, idx_q;
  logic        dest_d, dest_q;
  logic        a_valid_d, a_valid_q;
  logic        b_valid_d, b_valid_q;
  logic        busy_d, busy_q;
  logic        in_ready_d, in_ready_q;
  logic        done_d, done_q;
  logic        wr_s;
  logic [3:0]  wr_idx_s;
  logic        mirror_s;

  // Bank write position for the current transfer number.
  always_comb begin
`ifdef SYMM_ROUTE_SYMFILL_EN
    wr_idx_s = tri_lookup(idx_q);
    mirror_s = (wr_idx_s[3:2] != wr_idx_s[1:0]);
`else
    wr_idx_s = idx_q;
    mirror_s = 1'b0;
`endif
  end

  // FSM next state, transfer strobe and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dest_d     = dest_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    busy_d     = busy_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    wr_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_rt) begin
          state_d    = ST_LOAD;
          dest_d     = dest;
          idx_d      = 4'd0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
          if (dest) begin
            b_valid_d = 1'b0;
          end else begin
            a_valid_d = 1'b0;
          end
        end else begin
          busy_d     = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort_rt) begin
          // abort wins over a simultaneous transfer; its data is dropped
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b0;
        end else if (in_valid && in_ready_q) begin
          wr_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
            if (dest_q) begin
              b_valid_d = 1'b1;
            end else begin
              a_valid_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        in_ready_d = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk_rt or negedge rstn_rt) begin
    if (!rstn_rt) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      dest_q     <= 1'b0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dest_q     <= dest_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  symm_bank #(.DW(DW)) u_bank_a (
    .clk    (clk_rt),
    .rst_n  (rstn_rt),
    .we     (wr_s & ~dest_q),
    .mirror (mirror_s),
    .idx    (wr_idx_s),
    .wdata  (in_data),
    .mat    (oa_mat)
  );

  symm_bank #(.DW(DW)) u_bank_b (
    .clk    (clk_rt),
    .rst_n  (rstn_rt),
    .we     (wr_s & dest_q),
    .mirror (mirror_s),
    .idx    (wr_idx_s),
    .wdata  (in_data),
    .mat    (ob_mat)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a_valid  = a_valid_q;
  assign b_valid  = b_valid_q;

endmodule

// File: tb/tb_symm_route.sv
// Self-checking bench for symm_route. Reference model: two 16-entry arrays
// written at the (row,col) of each accepted element, plus mirrored position
// when built with SYMM_ROUTE_SYMFILL_EN.
module tb_symm_route;

  localparam int DW = 26;
`ifdef SYMM_ROUTE_SYMFILL_EN
  localparam int NE = 10;
`else
  localparam int NE = 16;
`endif

  logic                 clk_rt = 1'b0;
  logic                 rstn_rt;
  logic                 en_rt;
  logic                 dest;
  logic                 abort_rt;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic [16*DW-1:0]     oa_mat;
  logic [16*DW-1:0]     ob_mat;
  logic                 a_valid;
  logic                 b_valid;
  logic                 busy;
  logic                 done;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] ref_a [16];
  logic signed [DW-1:0] ref_b [16];
  logic                 ref_av;
  logic                 ref_bv;
  logic                 cur_bank;
  logic signed [DW-1:0] vals [16];

  always #5 clk_rt = ~clk_rt;

  symm_route #(.DW(DW), .N(4)) dut (
    .clk_rt   (clk_rt),
    .rstn_rt  (rstn_rt),
    .en_rt    (en_rt),
    .dest     (dest),
    .abort_rt (abort_rt),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .oa_mat   (oa_mat),
    .ob_mat   (ob_mat),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [16*DW-1:0] pack(input logic b);
    logic [16*DW-1:0] p;
    for (int i = 0; i < 16; i++) begin
      p[i*DW +: DW] = b ? ref_b[i] : ref_a[i];
    end
    return p;
  endfunction

  // Row-major position of the k-th transfer of a load.
  function automatic int pos_of(input int k);
`ifdef SYMM_ROUTE_SYMFILL_EN
    int n = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = r; c < 4; c++) begin
        if (n == k) return r * 4 + c;
        n++;
      end
    end
    return 0;
`else
    return k;
`endif
  endfunction

  task automatic model_write(input int k, input logic signed [DW-1:0] v);
    int p, r, c;
    p = pos_of(k);
    r = p / 4;
    c = p % 4;
    if (cur_bank) begin
      ref_b[p] = v;
`ifdef SYMM_ROUTE_SYMFILL_EN
      ref_b[c * 4 + r] = v;
`endif
    end else begin
      ref_a[p] = v;
`ifdef SYMM_ROUTE_SYMFILL_EN
      ref_a[c * 4 + r] = v;
`endif
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
    end
    ref_av = 1'b0;
    ref_bv = 1'b0;
  endtask

  task automatic chk_m(input string tag, input logic [16*DW-1:0] obs, input logic [16*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_busy, input logic e_done, input logic e_rdy);
    chk_m({tag, ".oa_mat"}, oa_mat, pack(1'b0));
    chk_m({tag, ".ob_mat"}, ob_mat, pack(1'b1));
    chk_b({tag, ".a_valid"}, a_valid, ref_av);
    chk_b({tag, ".b_valid"}, b_valid, ref_bv);
    chk_b({tag, ".busy"}, busy, e_busy);
    chk_b({tag, ".done"}, done, e_done);
    chk_b({tag, ".in_ready"}, in_ready, e_rdy);
  endtask

  // One load into bank. vpat: 0 continuous valid, 1 every other cycle,
  // 2 random. abort_at / reset_at: transfer number at which to abort or reset
  // (-1 = never). toggle: wiggle en_rt/dest during the load.
  task automatic run_load(input logic bank, input int vpat, input int abort_at,
                          input int reset_at, input logic toggle);
    int k = 0;
    int cyc = 0;
    en_rt    = 1'b1;
    dest     = bank;
    in_valid = 1'b0;
    @(posedge clk_rt); @(negedge clk_rt);
    en_rt    = 1'b0;
    dest     = ~bank;
    cur_bank = bank;
    if (bank) ref_bv = 1'b0; else ref_av = 1'b0;
    chk_all("start", 1'b1, 1'b0, 1'b1);
    while (k < NE && cyc < 200) begin
      cyc++;
      case (vpat)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = vals[k];
      if (toggle) begin
        en_rt = 1'($urandom_range(0, 1));
        dest  = 1'($urandom_range(0, 1));
      end
      if (k == reset_at && in_valid) begin
        rstn_rt = 1'b0;
        #1;
        model_clear();
        chk_all("reset_imm", 1'b0, 1'b0, 1'b0);
        @(posedge clk_rt); @(negedge clk_rt);
        rstn_rt  = 1'b1;
        in_valid = 1'b0;
        en_rt    = 1'b0;
        repeat (3) begin
          @(posedge clk_rt); @(negedge clk_rt);
          chk_all("after_reset", 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      abort_rt = (k == abort_at);
      @(posedge clk_rt); @(negedge clk_rt);
      if (abort_rt) begin
        abort_rt = 1'b0;
        in_valid = 1'b0;
        en_rt    = 1'b0;
        chk_all("abort", 1'b0, 1'b0, 1'b0);
        repeat (2) begin
          @(posedge clk_rt); @(negedge clk_rt);
          chk_all("post_abort", 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      if (in_valid) begin
        model_write(k, vals[k]);
        k++;
      end
      en_rt = 1'b0;
      if (k < NE) chk_all("load", 1'b1, 1'b0, 1'b1);
    end
    checks++;
    assert (k == NE) else begin
      errors++;
      $error("FAIL load_timeout observed=%0d expected=%0d", k, NE);
    end
    if (bank) ref_bv = 1'b1; else ref_av = 1'b1;
    // junk offered during DONE and the following IDLE must be ignored
    in_valid = 1'b1;
    in_data  = DW'($urandom());
    en_rt    = 1'b0;
    chk_all("done", 1'b0, 1'b1, 1'b0);
    @(posedge clk_rt); @(negedge clk_rt);
    chk_all("idle", 1'b0, 1'b0, 1'b0);
    @(posedge clk_rt); @(negedge clk_rt);
    in_valid = 1'b0;
    chk_all("idle2", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn_rt  = 1'b0;
    en_rt    = 1'b0;
    dest     = 1'b0;
    abort_rt = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cur_bank = 1'b0;
    model_clear();
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk_rt); @(negedge clk_rt);
    rstn_rt = 1'b1;
    @(negedge clk_rt);
    chk_all("reset_release", 1'b0, 1'b0, 1'b0);

    // bank A, ascending 1.., continuous valid
    for (int i = 0; i < 16; i++) vals[i] = DW'(i + 1);
    run_load(1'b0, 0, -1, -1, 1'b0);

    // bank B, -1..-16, valid every other cycle
    for (int i = 0; i < 16; i++) vals[i] = DW'(-(i + 1));
    run_load(1'b1, 1, -1, -1, 1'b0);

    // bank A aborted after 5 transfers (abort collides with 6th transfer)
    for (int i = 0; i < 16; i++) vals[i] = DW'($urandom());
    run_load(1'b0, 0, 5, -1, 1'b0);

    // bank A full reload must restart at element 0
    for (int i = 0; i < 16; i++) vals[i] = DW'($urandom());
    run_load(1'b0, 2, -1, -1, 1'b0);

    // bank B interrupted by reset after 8 transfers
    for (int i = 0; i < 16; i++) vals[i] = DW'($urandom());
    run_load(1'b1, 0, -1, 8, 1'b0);

    // bank B full load after reset, random stalls
    for (int i = 0; i < 16; i++) vals[i] = DW'($urandom());
    run_load(1'b1, 2, -1, -1, 1'b0);

    // bank A with en_rt/dest wiggling during the load
    for (int i = 0; i < 16; i++) vals[i] = DW'($urandom());
    run_load(1'b0, 2, -1, -1, 1'b1);

    // bank B with values 10..
    for (int i = 0; i < 16; i++) vals[i] = DW'(10 + i);
    run_load(1'b1, 0, -1, -1, 1'b0);

    // idle: valid data and abort without en_rt change nothing
    in_valid = 1'b1;
    abort_rt = 1'b1;
    repeat (3) begin
      in_data = DW'($urandom());
      @(posedge clk_rt); @(negedge clk_rt);
      chk_all("idle_ignore", 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    abort_rt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
